// File: rtl/fpmul_rr_arbiter_if.sv
// Handshake bundles for the shared-multiplier arbiter: the client-facing
// request/response bus and the operand/product link to the multiplier.
interface fpmul_req_if #(
    parameter int NREQ = 4,
    parameter int N    = 32
);
    logic [NREQ-1:0]   req_val;
    logic [NREQ-1:0]   req_rdy;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   resp_val;
    logic [NREQ-1:0]   resp_rdy;
    logic [N-1:0]      resp_c;
    logic              resp_err;

    // Clients drive requests and response acceptance.
    modport master (
        output req_val, req_a, req_b, resp_rdy,
        input  req_rdy, resp_val, resp_c, resp_err
    );

    modport slave (
        input  req_val, req_a, req_b, resp_rdy,
        output req_rdy, resp_val, resp_c, resp_err
    );
endinterface

interface fpmul_mul_if #(
    parameter int N = 32
);
    logic         mul_snd_val;
    logic         mul_snd_rdy;
    logic [N-1:0] mul_a;
    logic [N-1:0] mul_b;
    logic         mul_rcv_val;
    logic         mul_rcv_rdy;
    logic [N-1:0] mul_c;

    // The arbiter is the master of the multiplier link.
    modport master (
        output mul_snd_val, mul_a, mul_b, mul_rcv_rdy,
        input  mul_snd_rdy, mul_rcv_val, mul_c
    );

    modport slave (
        input  mul_snd_val, mul_a, mul_b, mul_rcv_rdy,
        output mul_snd_rdy, mul_rcv_val, mul_c
    );
endinterface

// File: rtl/fpmul_rr_arbiter.sv
// Round-robin controller time-sharing one iterative multiplier among NREQ clients.
// Optional WAIT watchdog enabled by defining FPMUL_ARB_WATCHDOG_EN.
module fpmul_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int N       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    fpmul_req_if.slave  req,
    fpmul_mul_if.master mul
);
    localparam int            IW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_ID = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_reg, state_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [IW-1:0] id_reg, id_next;
    logic [N-1:0]  opa_reg, opa_next;
    logic [N-1:0]  opb_reg, opb_next;
    logic [N-1:0]  res_reg, res_next;

`ifdef FPMUL_ARB_WATCHDOG_EN
    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          err_reg, err_next;
`endif

    logic [N-1:0] a_slice [NREQ];
    logic [N-1:0] b_slice [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_slice[gi] = req.req_a[gi*N +: N];
            assign b_slice[gi] = req.req_b[gi*N +: N];
        end
    endgenerate

    // Rotating priority: scan from the far end so the slot closest to ptr wins.
    logic          grant_any;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr_reg) + k) % NREQ);
            if (req.req_val[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            id_reg    <= '0;
            opa_reg   <= '0;
            opb_reg   <= '0;
            res_reg   <= '0;
`ifdef FPMUL_ARB_WATCHDOG_EN
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            id_reg    <= id_next;
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            res_reg   <= res_next;
`ifdef FPMUL_ARB_WATCHDOG_EN
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        id_next    = id_reg;
        opa_next   = opa_reg;
        opb_next   = opb_reg;
        res_next   = res_reg;
`ifdef FPMUL_ARB_WATCHDOG_EN
        cnt_next   = cnt_reg;
        err_next   = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                // A product drained here is a leftover from a reset mid-op.
                if (grant_any) begin
                    opa_next   = a_slice[grant_idx];
                    opb_next   = b_slice[grant_idx];
                    id_next    = grant_idx;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (mul.mul_snd_rdy) begin
                    state_next = WAIT;
`ifdef FPMUL_ARB_WATCHDOG_EN
                    cnt_next   = '0;
`endif
                end
            end
            WAIT: begin
                if (mul.mul_rcv_val) begin
                    res_next   = mul.mul_c;
                    state_next = RESP;
`ifdef FPMUL_ARB_WATCHDOG_EN
                    err_next   = 1'b0;
                end else if (cnt_reg == CNT_LAST) begin
                    // A product arriving on the timeout cycle still wins above.
                    res_next   = '0;
                    err_next   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next   = cnt_reg + CW'(1);
`endif
                end
            end
            RESP: begin
                if (req.resp_rdy[id_reg]) begin
                    ptr_next   = (id_reg == LAST_ID) ? '0 : id_reg + IW'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, including the combinational grant.
    always_comb begin
        req.req_rdy     = '0;
        req.resp_val    = '0;
        req.resp_c      = '0;
        req.resp_err    = 1'b0;
        mul.mul_snd_val = 1'b0;
        mul.mul_a       = '0;
        mul.mul_b       = '0;
        mul.mul_rcv_rdy = 1'b0;
        if (!reset) begin
            case (state_reg)
                IDLE: begin
                    req.req_rdy[grant_idx] = grant_any;
                    mul.mul_rcv_rdy        = 1'b1;
                end
                ISSUE: begin
                    mul.mul_snd_val = 1'b1;
                    mul.mul_a       = opa_reg;
                    mul.mul_b       = opb_reg;
                end
                WAIT: begin
                    mul.mul_rcv_rdy = 1'b1;
                end
                RESP: begin
                    req.resp_val[id_reg] = 1'b1;
                    req.resp_c           = res_reg;
`ifdef FPMUL_ARB_WATCHDOG_EN
                    req.resp_err         = err_reg;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
